// File: rtl/gpio_port_ctrl.sv
// rtl/gpio_port_ctrl.sv - 8-pin GPIO port with register control, synchronized/debounced inputs and edge interrupts
module gpio_port_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic [7:0] pad_a,
    output logic [7:0] pad_oe,
    output logic [7:0] pad_pu,
    output logic [7:0] pad_pd,
    input  logic [7:0] pad_y,
    output logic       irq
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_PU   = 3'd2;
    localparam logic [2:0] A_PD   = 3'd3;
    localparam logic [2:0] A_IN   = 3'd4;
    localparam logic [2:0] A_EN   = 3'd5;
    localparam logic [2:0] A_TYPE = 3'd6;
    localparam logic [2:0] A_STAT = 3'd7;

    logic [7:0]    out_q, dir_q, pu_q, pd_q, en_q, type_q, stat_q, db_q;
    logic [7:0]    sync_q [SYNC_STAGES];
    logic [CW-1:0] cnt_q [8];
    logic [CW-1:0] cnt_next [8];
    logic [7:0]    sync_y, db_next, events, w1c, rd_mux;
    logic          irq_q;

    assign sync_y = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pad_y;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // A pin's count restarts whenever the synced level agrees with db again.
    always_comb begin
        db_next = db_q;
        for (int i = 0; i < 8; i++) begin
            cnt_next[i] = '0;
            if (sync_y[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_next[i] = sync_y[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign events = ((db_next & ~db_q & ~type_q) | (~db_next & db_q & type_q)) & en_q;
    assign w1c    = (wr_en && addr == A_STAT) ? wdata : 8'h00;

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            A_OUT:   rd_mux = out_q;
            A_DIR:   rd_mux = dir_q;
            A_PU:    rd_mux = pu_q;
            A_PD:    rd_mux = pd_q;
            A_IN:    rd_mux = db_q;
            A_EN:    rd_mux = en_q;
            A_TYPE:  rd_mux = type_q;
            A_STAT:  rd_mux = stat_q;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            dir_q       <= '0;
            pu_q        <= '0;
            pd_q        <= '0;
            en_q        <= '0;
            type_q      <= '0;
            stat_q      <= '0;
            db_q        <= '0;
            irq_q       <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            db_q <= db_next;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_next[i];
            // Event set is ORed after the clear so a coincident new event survives.
            stat_q      <= (stat_q & ~w1c) | events;
            irq_q       <= |(stat_q & en_q);
            rdata_valid <= rd_en;
            if (rd_en) rdata <= rd_mux;
            if (wr_en) begin
                case (addr)
                    A_OUT:  out_q <= wdata;
                    A_DIR:  dir_q <= wdata;
                    A_PU: begin
                        pu_q <= wdata;
                        pd_q <= pd_q & ~wdata;
                    end
                    A_PD: begin
                        pd_q <= wdata;
                        pu_q <= pu_q & ~wdata;
                    end
                    A_EN:   en_q   <= wdata;
                    A_TYPE: type_q <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign pad_a  = out_q;
    assign pad_oe = dir_q;
    assign pad_pu = pu_q;
    assign pad_pd = pd_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb/tb_gpio_port_ctrl.sv - self-checking bench for gpio_port_ctrl with a behavioural reference model
module tb_gpio_port_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] pad_y = 8'h00;
    logic [7:0] rdata, pad_a, pad_oe, pad_pu, pad_pd;
    logic       rdata_valid, irq;

    int tests_run = 0;
    int tests_failed = 0;

    gpio_port_ctrl #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .pad_a(pad_a), .pad_oe(pad_oe), .pad_pu(pad_pu), .pad_pd(pad_pd),
        .pad_y(pad_y), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference state: registers by name, db level per pin, run length of disagreement per pin
    logic [7:0] m_out, m_dir, m_pu, m_pd, m_en, m_type, m_stat, m_db, m_rdata;
    logic       m_rv, m_irq;
    int         m_run [8];
    logic [7:0] m_hist [$];

    function automatic logic [7:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0: return m_out;
            3'd1: return m_dir;
            3'd2: return m_pu;
            3'd3: return m_pd;
            3'd4: return m_db;
            3'd5: return m_en;
            3'd6: return m_type;
            default: return m_stat;
        endcase
    endfunction

    // Advances the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        logic [7:0] seen, ev, clr;
        if (rst) begin
            {m_out, m_dir, m_pu, m_pd, m_en, m_type, m_stat, m_db, m_rdata} = '0;
            m_rv = 1'b0;
            m_irq = 1'b0;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
            m_hist.delete();
            for (int s = 0; s < SYNC_STAGES; s++) m_hist.push_back(8'h00);
        end else begin
            m_irq = |(m_stat & m_en);
            m_rv = rd_en;
            if (rd_en) m_rdata = m_reg(addr);
            seen = m_hist[0];
            ev = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (seen[i] != m_db[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DB_CYCLES) begin
                        m_run[i] = 0;
                        m_db[i] = seen[i];
                        ev[i] = (seen[i] != m_type[i]);
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            void'(m_hist.pop_front());
            m_hist.push_back(pad_y);
            clr = (wr_en && addr == 3'd7) ? wdata : 8'h00;
            m_stat = (m_stat & ~clr) | (ev & m_en);
            if (wr_en) begin
                case (addr)
                    3'd0: m_out = wdata;
                    3'd1: m_dir = wdata;
                    3'd2: begin m_pu = wdata; m_pd = m_pd & ~wdata; end
                    3'd3: begin m_pd = wdata; m_pu = m_pu & ~wdata; end
                    3'd5: m_en = wdata;
                    3'd6: m_type = wdata;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [7:0] d, output logic v);
        rd_en = 1'b1; addr = a;
        step();
        rd_en = 1'b0;
        d = rdata;
        v = rdata_valid;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic v;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        tests_run++;
        if (pad_oe !== 8'h00 || pad_pu !== 8'h00 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: pad_oe=%h pad_pu=%h irq=%b, required 00 00 0", pad_oe, pad_pu, irq);
        end
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a), d, v);
            tests_run++;
            if (d !== 8'h00 || v !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_read_%0d: rdata=%h valid=%b, required 00 1", a, d, v);
            end
        end
    endtask

    task automatic test_output_drive();
        logic [7:0] d; logic v;
        do_write(3'd1, 8'hF0);
        tests_run++;
        if (pad_oe !== 8'hF0) begin
            tests_failed++;
            $display("FAIL drive_oe: pad_oe=%h, required f0", pad_oe);
        end
        do_write(3'd0, 8'hA5);
        tests_run++;
        if (pad_a !== 8'hA5) begin
            tests_failed++;
            $display("FAIL drive_a: pad_a=%h, required a5", pad_a);
        end
        do_read(3'd0, d, v);
        tests_run++;
        if (d !== 8'hA5 || v !== 1'b1) begin
            tests_failed++;
            $display("FAIL drive_read: rdata=%h valid=%b, required a5 1", d, v);
        end
        step();
        tests_run++;
        if (rdata_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL valid_pulse: rdata_valid=%b, required 0", rdata_valid);
        end
    endtask

    task automatic test_pull_exclusion();
        logic [7:0] d; logic v;
        do_write(3'd2, 8'hFF);
        do_write(3'd3, 8'h0F);
        tests_run++;
        if (pad_pu !== 8'hF0 || pad_pd !== 8'h0F) begin
            tests_failed++;
            $display("FAIL pull_pads: pad_pu=%h pad_pd=%h, required f0 0f", pad_pu, pad_pd);
        end
        do_read(3'd2, d, v);
        tests_run++;
        if (d !== 8'hF0) begin
            tests_failed++;
            $display("FAIL pull_read: rdata=%h, required f0", d);
        end
    endtask

    task automatic test_debounce();
        logic [7:0] d; logic v;
        pad_y = 8'h08;
        step(3);
        pad_y = 8'h00;
        step(8);
        do_read(3'd4, d, v);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("FAIL glitch_in: IN=%h, required 00", d);
        end
        pad_y = 8'h08;
        step(5);
        do_read(3'd4, d, v);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("FAIL db_early: IN before edge 6=%h, required 00", d);
        end
        do_read(3'd4, d, v);
        tests_run++;
        if (d !== 8'h08) begin
            tests_failed++;
            $display("FAIL db_edge6: IN after edge 6=%h, required 08", d);
        end
    endtask

    task automatic test_interrupt();
        logic [7:0] d; logic v;
        do_write(3'd5, 8'h09);
        do_write(3'd6, 8'h08);
        pad_y = 8'h09;
        step(6);
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_early: irq=%b at edge 6, required 0", irq);
        end
        step();
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_edge7: irq=%b at edge 7, required 1", irq);
        end
        do_read(3'd7, d, v);
        tests_run++;
        if (d !== 8'h01) begin
            tests_failed++;
            $display("FAIL stat_rise: IRQ_STAT=%h, required 01", d);
        end
        pad_y = 8'h01;
        step(8);
        do_read(3'd7, d, v);
        tests_run++;
        if (d !== 8'h09) begin
            tests_failed++;
            $display("FAIL stat_fall: IRQ_STAT=%h, required 09", d);
        end
        do_write(3'd7, 8'h01);
        do_read(3'd7, d, v);
        tests_run++;
        if (d !== 8'h08 || irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL w1c_partial: IRQ_STAT=%h irq=%b, required 08 1", d, irq);
        end
        do_write(3'd7, 8'h08);
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_hold: irq=%b at W1C edge, required 1", irq);
        end
        step();
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_clear: irq=%b one edge after W1C, required 0", irq);
        end
    endtask

    task automatic test_collision();
        logic [7:0] d; logic v;
        pad_y = 8'h00;
        step(8);
        pad_y = 8'h01;
        step(5);
        do_write(3'd7, 8'h01);
        do_read(3'd7, d, v);
        tests_run++;
        if (d[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision: IRQ_STAT=%h, required bit0=1", d);
        end
        do_write(3'd7, 8'hFF);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic v;
        do_write(3'd6, 8'h09);
        pad_y = 8'h00;
        step(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_read(3'd4, d, v);
        tests_run++;
        if (d !== 8'h00 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid: IN=%h irq=%b, required 00 0", d, irq);
        end
        do_write(3'd5, 8'h01);
        pad_y = 8'h01;
        for (int e = 1; e <= 6; e++) begin
            step();
            tests_run++;
            if (irq !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_no_event: irq=%b at edge %0d, required 0", irq, e);
            end
        end
        step();
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_new_event: irq=%b at edge 7, required 1", irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        logic [7:0] vals [3];
        vals[0] = 8'h3C; vals[1] = 8'hC3; vals[2] = 8'h5A;
        exp_d[0] = 8'h00; exp_d[1] = 8'h3C; exp_d[2] = 8'hC3;
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; addr = 3'd1; wdata = vals[k];
            step();
            tests_run++;
            if (rdata !== exp_d[k] || rdata_valid !== 1'b1 || pad_oe !== vals[k]) begin
                tests_failed++;
                $display("FAIL b2b_%0d: rdata=%h valid=%b pad_oe=%h, required %h 1 %h",
                         k, rdata, rdata_valid, pad_oe, exp_d[k], vals[k]);
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            wr_en = ($urandom_range(0, 2) == 0);
            rd_en = ($urandom_range(0, 2) == 0);
            addr  = 3'($urandom_range(0, 7));
            wdata = 8'($urandom);
            if ($urandom_range(0, 5) == 0) pad_y = pad_y ^ (8'h01 << $urandom_range(0, 7));
            step();
            tests_run++;
            if (pad_a !== m_out || pad_oe !== m_dir || pad_pu !== m_pu || pad_pd !== m_pd ||
                irq !== m_irq || rdata_valid !== m_rv || (m_rv && rdata !== m_rdata)) begin
                tests_failed++;
                $display("FAIL random_c%0d: a/oe/pu/pd=%h/%h/%h/%h irq=%b v=%b rdata=%h, required %h/%h/%h/%h %b %b %h",
                         c, pad_a, pad_oe, pad_pu, pad_pd, irq, rdata_valid, rdata,
                         m_out, m_dir, m_pu, m_pd, m_irq, m_rv, m_rdata);
            end
        end
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_output_drive();
        test_pull_exclusion();
        test_debounce();
        test_interrupt();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
